// File: rtl/input_debounce_if.sv
// -----------------------------------------------------------------------------
// input_debounce_if
// Groups the raw inputs, the glitch-counter clear and the debounced outputs of
// input_debounce into a single bundle. clk and reset are not part of the
// bundle; they stay plain ports on the module.
//
// Signals:
//   a_raw, b_raw, c_raw  raw asynchronous levels (driven by master)
//   glitch_clr           synchronous clear of glitch_cnt (driven by master)
//   a, b, c              debounced levels (driven by slave)
//   changed              one-cycle pulse when any of a/b/c flips (slave)
//   glitch_cnt[7:0]      saturating count of aborted transitions (slave)
//   a_rise, b_rise, c_rise  0->1 pulses, only when INPUT_DEBOUNCE_EDGE_EN
//                           is defined (slave)
//
// Modports: master = stimulus/consumer side, slave = the debouncer.
// -----------------------------------------------------------------------------
interface input_debounce_if;
   logic       a_raw;
   logic       b_raw;
   logic       c_raw;
   logic       glitch_clr;
   logic       a;
   logic       b;
   logic       c;
   logic       changed;
   logic [7:0] glitch_cnt;
`ifdef INPUT_DEBOUNCE_EDGE_EN
   logic       a_rise;
   logic       b_rise;
   logic       c_rise;

   modport master (
      output a_raw, b_raw, c_raw, glitch_clr,
      input  a, b, c, changed, glitch_cnt, a_rise, b_rise, c_rise
   );
   modport slave (
      input  a_raw, b_raw, c_raw, glitch_clr,
      output a, b, c, changed, glitch_cnt, a_rise, b_rise, c_rise
   );
`else
   modport master (
      output a_raw, b_raw, c_raw, glitch_clr,
      input  a, b, c, changed, glitch_cnt
   );
   modport slave (
      input  a_raw, b_raw, c_raw, glitch_clr,
      output a, b, c, changed, glitch_cnt
   );
`endif
endinterface

// File: rtl/input_debounce.sv
// -----------------------------------------------------------------------------
// input_debounce
// Three-channel debouncer for asynchronous buttons/strobes. Each channel is
// synchronized through two flops, then a per-channel counter requires
// DB_CYCLES consecutive mismatching cycles before the debounced output takes
// the new level. A mismatch run that ends early is an aborted transition
// (glitch) and bumps a shared saturating 8-bit counter.
//
// Parameter:
//   DB_CYCLES  consecutive mismatch cycles before a flip, 1..255 (default 4)
//
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous, active-high reset
//   bus    input_debounce_if.slave (raw inputs, glitch_clr, debounced
//          outputs, changed pulse, glitch_cnt, optional rise pulses)
//
// Optional feature macro: INPUT_DEBOUNCE_EDGE_EN
//   Defined   -> a_rise/b_rise/c_rise pulse for one cycle on a 0->1 flip.
//   Undefined -> no rise outputs or logic.
//
// Latency: a raw level first sampled at edge N appears on its output at edge
// N + DB_CYCLES + 1 (two synchronizer stages, then DB_CYCLES-1 counting edges
// plus the flipping edge).
// -----------------------------------------------------------------------------
module input_debounce #(
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input_debounce_if.slave        bus
);

   localparam int unsigned     CNT_W    = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   // Channel index 0 = a, 1 = b, 2 = c.
   logic [2:0]       w_raw;
   logic [2:0]       r_s1;
   logic [2:0]       r_s2;
   logic [2:0]       r_out;
   logic [CNT_W-1:0] r_cnt [3];
   logic             r_changed;
   logic [7:0]       r_glitch_cnt;

   logic [2:0]       w_mismatch;
   logic [2:0]       w_flip;
   logic [2:0]       w_abort;

   assign w_raw = {bus.c_raw, bus.b_raw, bus.a_raw};

   // Per-channel decisions for this edge. A channel flips when it has
   // already seen DB_CYCLES-1 mismatches and sees one more; it aborts when
   // the synchronized level returns to the output while still PENDING.
   always_comb begin
      // NOTE: every always_comb output gets a default before any branch so
      // no path leaves it unassigned, which would infer a latch.
      w_mismatch = '0;
      w_flip     = '0;
      w_abort    = '0;
      for (int i = 0; i < 3; i++) begin
         w_mismatch[i] = r_s2[i] ^ r_out[i];
         w_flip[i]     = w_mismatch[i] && (r_cnt[i] == CNT_LAST);
         w_abort[i]    = !w_mismatch[i] && (r_cnt[i] != '0);
      end
   end

   // NOTE: sequential state is updated only with non-blocking assignments so
   // every flop samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1         <= '0;
         r_s2         <= '0;
         r_out        <= '0;
         r_changed    <= 1'b0;
         r_glitch_cnt <= '0;
         // NOTE: r_cnt is a small flop array, not a RAM, so it is cleared
         // here; this is what discards a transition pending at reset.
         for (int i = 0; i < 3; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_s1 <= w_raw;
         r_s2 <= r_s1;
         for (int i = 0; i < 3; i++) begin
            if (w_flip[i]) begin
               r_out[i] <= r_s2[i];
               r_cnt[i] <= '0;
            end else if (w_mismatch[i]) begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end else begin
               r_cnt[i] <= '0;
            end
         end
         // One pulse per flipping edge, however many channels flip.
         r_changed <= |w_flip;
         // Clear wins over a same-edge increment; the count never wraps.
         if (bus.glitch_clr) begin
            r_glitch_cnt <= '0;
         end else if ((|w_abort) && (r_glitch_cnt != 8'hFF)) begin
            r_glitch_cnt <= r_glitch_cnt + 8'd1;
         end
      end
   end

   assign bus.a          = r_out[0];
   assign bus.b          = r_out[1];
   assign bus.c          = r_out[2];
   assign bus.changed    = r_changed;
   assign bus.glitch_cnt = r_glitch_cnt;

`ifdef INPUT_DEBOUNCE_EDGE_EN
   logic [2:0] r_rise;

   // A flip whose new level is 1 is a rising edge of the debounced output.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rise <= '0;
      end else begin
         r_rise <= w_flip & r_s2;
      end
   end

   assign bus.a_rise = r_rise[0];
   assign bus.b_rise = r_rise[1];
   assign bus.c_rise = r_rise[2];
`endif

endmodule

// File: tb/tb_input_debounce.sv
// -----------------------------------------------------------------------------
// tb_input_debounce
// Self-checking bench for input_debounce. Stimulus for each cycle is queued
// together with the expected snapshot of the outputs after that edge; each
// scenario task then plays its queue and compares cycle by cycle.
// A second instance with DB_CYCLES=1 covers the minimum-latency boundary.
// Snapshot layout: {a_rise,b_rise,c_rise, a,b,c, changed, glitch_cnt[7:0]}.
// -----------------------------------------------------------------------------
module tb_input_debounce;
   localparam int DB = 4;

`ifdef INPUT_DEBOUNCE_EDGE_EN
   localparam logic [2:0] RISE_MASK = 3'b111;
`else
   localparam logic [2:0] RISE_MASK = 3'b000;
`endif

   typedef struct packed {
      logic rst;
      logic clr;
      logic a;
      logic b;
      logic c;
   } stim_t;
   typedef logic [14:0] snap_t;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   input_debounce_if bus  ();
   input_debounce_if bus1 ();

   input_debounce #(.DB_CYCLES(DB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   input_debounce #(.DB_CYCLES(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.slave)
   );

   stim_t      stim_q [$];
   snap_t      exp_q  [$];
   int         tests = 0;
   int         fails = 0;
   logic [7:0] exp_g = 8'd0;

   function automatic stim_t st(logic rst, logic clr, logic a, logic b, logic c);
      stim_t s;
      s.rst = rst; s.clr = clr; s.a = a; s.b = b; s.c = c;
      return s;
   endfunction

   // Expected snapshot; rise bits only exist in the EDGE_EN build.
   function automatic snap_t mk(logic [2:0] abc, logic chg, logic [2:0] rise,
                                logic [7:0] g);
      return {rise & RISE_MASK, abc, chg, g};
   endfunction

   function automatic snap_t observe();
      logic [2:0] r;
`ifdef INPUT_DEBOUNCE_EDGE_EN
      r = {bus.a_rise, bus.b_rise, bus.c_rise};
`else
      r = 3'b000;
`endif
      return {r, bus.a, bus.b, bus.c, bus.changed, bus.glitch_cnt};
   endfunction

   task automatic push(input stim_t s, input snap_t e);
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   // Drive one queued stimulus, let one rising edge pass, sample 1 ns later.
   task automatic apply_and_sample(output snap_t obs);
      stim_t s;
      s = stim_q.pop_front();
      reset          = s.rst;
      bus.glitch_clr = s.clr;
      bus.a_raw      = s.a;
      bus.b_raw      = s.b;
      bus.c_raw      = s.c;
      @(posedge clk);
      #1;
      obs = observe();
   endtask

   task automatic test_reset();
      snap_t obs, e;
      int    idx = 0;
      for (int i = 0; i < 3; i++) push(st(1, 0, 0, 0, 0), mk(3'b000, 0, 3'b000, 8'd0));
      exp_g = 8'd0;
      while (exp_q.size() != 0) begin
         apply_and_sample(obs);
         e = exp_q.pop_front();
         tests++;
         if (obs !== e) begin
            fails++;
            $display("FAIL reset idx=%0d got=%h exp=%h", idx, obs, e);
         end
         idx++;
      end
      tests++;
      if ({bus1.a, bus1.b, bus1.c, bus1.changed, bus1.glitch_cnt} !== 12'h000) begin
         fails++;
         $display("FAIL reset_db1 got=%h exp=000",
                  {bus1.a, bus1.b, bus1.c, bus1.changed, bus1.glitch_cnt});
      end
   endtask

   // a rises and holds: flip DB+1 edges after first sample, then falls back.
   task automatic test_latency();
      snap_t obs, e;
      int    idx = 0;
      for (int i = 0; i < 8; i++)
         push(st(0, 0, 1, 0, 0), (i < 5)  ? mk(3'b000, 0, 3'b000, exp_g) :
                                 (i == 5) ? mk(3'b100, 1, 3'b100, exp_g) :
                                            mk(3'b100, 0, 3'b000, exp_g));
      for (int i = 0; i < 8; i++)
         push(st(0, 0, 0, 0, 0), (i < 5)  ? mk(3'b100, 0, 3'b000, exp_g) :
                                 (i == 5) ? mk(3'b000, 1, 3'b000, exp_g) :
                                            mk(3'b000, 0, 3'b000, exp_g));
      while (exp_q.size() != 0) begin
         apply_and_sample(obs);
         e = exp_q.pop_front();
         tests++;
         if (obs !== e) begin
            fails++;
            $display("FAIL latency idx=%0d got=%h exp=%h", idx, obs, e);
         end
         idx++;
      end
   endtask

   // b pulses of 2 and DB-1 cycles: no flip, no changed, one glitch each,
   // counted L+2 edges after the pulse starts.
   task automatic test_glitch();
      snap_t obs, e;
      int    idx = 0;
      for (int len = 2; len <= DB - 1; len++) begin
         for (int i = 0; i < 8; i++) begin
            if (i == len + 2) exp_g = exp_g + 8'd1;
            push(st(0, 0, 0, (i < len) ? 1'b1 : 1'b0, 0), mk(3'b000, 0, 3'b000, exp_g));
         end
      end
      while (exp_q.size() != 0) begin
         apply_and_sample(obs);
         e = exp_q.pop_front();
         tests++;
         if (obs !== e) begin
            fails++;
            $display("FAIL glitch idx=%0d got=%h exp=%h", idx, obs, e);
         end
         idx++;
      end
   endtask

   // a and c rise together: one shared flip edge, single changed pulse.
   task automatic test_simultaneous();
      snap_t obs, e;
      int    idx = 0;
      for (int i = 0; i < 8; i++)
         push(st(0, 0, 1, 0, 1), (i < 5)  ? mk(3'b000, 0, 3'b000, exp_g) :
                                 (i == 5) ? mk(3'b101, 1, 3'b101, exp_g) :
                                            mk(3'b101, 0, 3'b000, exp_g));
      for (int i = 0; i < 8; i++)
         push(st(0, 0, 0, 0, 0), (i < 5)  ? mk(3'b101, 0, 3'b000, exp_g) :
                                 (i == 5) ? mk(3'b000, 1, 3'b000, exp_g) :
                                            mk(3'b000, 0, 3'b000, exp_g));
      while (exp_q.size() != 0) begin
         apply_and_sample(obs);
         e = exp_q.pop_front();
         tests++;
         if (obs !== e) begin
            fails++;
            $display("FAIL simultaneous idx=%0d got=%h exp=%h", idx, obs, e);
         end
         idx++;
      end
   endtask

   // 300 one-cycle glitches saturate at 255; clear wins over a same-edge
   // abort; counting resumes from zero afterwards.
   task automatic test_saturate();
      snap_t obs, e;
      int    idx = 0;
      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < 4; i++) begin
            if (i == 3 && exp_g != 8'hFF) exp_g = exp_g + 8'd1;
            push(st(0, 0, 0, (i == 0) ? 1'b1 : 1'b0, 0), mk(3'b000, 0, 3'b000, exp_g));
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (i == 3) exp_g = 8'd0;
         push(st(0, (i == 3) ? 1'b1 : 1'b0, 0, (i == 0) ? 1'b1 : 1'b0, 0),
              mk(3'b000, 0, 3'b000, exp_g));
      end
      for (int i = 0; i < 4; i++) begin
         if (i == 3) exp_g = 8'd1;
         push(st(0, 0, 0, (i == 0) ? 1'b1 : 1'b0, 0), mk(3'b000, 0, 3'b000, exp_g));
      end
      while (exp_q.size() != 0) begin
         apply_and_sample(obs);
         e = exp_q.pop_front();
         tests++;
         if (obs !== e) begin
            fails++;
            $display("FAIL saturate idx=%0d got=%h exp=%h", idx, obs, e);
         end
         idx++;
      end
   endtask

   // c held high; reset hits with cnt=2 pending. Nothing flips or counts,
   // and c reappears at R+DB+1 with R the first edge after reset.
   task automatic test_reset_pending();
      snap_t obs, e;
      int    idx = 0;
      for (int i = 0; i < 13; i++) begin
         if (i == 4) exp_g = 8'd0;
         push(st((i == 4) ? 1'b1 : 1'b0, 0, 0, 0, 1),
              (i < 10)  ? mk(3'b000, 0, 3'b000, exp_g) :
              (i == 10) ? mk(3'b001, 1, 3'b001, exp_g) :
                          mk(3'b001, 0, 3'b000, exp_g));
      end
      for (int i = 0; i < 8; i++)
         push(st(0, 0, 0, 0, 0), (i < 5)  ? mk(3'b001, 0, 3'b000, exp_g) :
                                 (i == 5) ? mk(3'b000, 1, 3'b000, exp_g) :
                                            mk(3'b000, 0, 3'b000, exp_g));
      while (exp_q.size() != 0) begin
         apply_and_sample(obs);
         e = exp_q.pop_front();
         tests++;
         if (obs !== e) begin
            fails++;
            $display("FAIL reset_pending idx=%0d got=%h exp=%h", idx, obs, e);
         end
         idx++;
      end
   endtask

   // DB_CYCLES=1 instance: flip appears two edges after the first sample.
   task automatic test_db1();
      logic [1:0] q [$];
      logic [1:0] e, obs;
      for (int i = 0; i < 5; i++)
         q.push_back((i < 2) ? 2'b00 : (i == 2) ? 2'b11 : 2'b10);
      bus1.a_raw = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         obs = {bus1.a, bus1.changed};
         e   = q.pop_front();
         tests++;
         if (obs !== e) begin
            fails++;
            $display("FAIL db1_latency idx=%0d got=%b exp=%b", i, obs, e);
         end
      end
      bus1.a_raw = 1'b0;
   endtask

   initial begin
      reset           = 1'b1;
      bus.glitch_clr  = 1'b0;
      bus.a_raw       = 1'b0;
      bus.b_raw       = 1'b0;
      bus.c_raw       = 1'b0;
      bus1.glitch_clr = 1'b0;
      bus1.a_raw      = 1'b0;
      bus1.b_raw      = 1'b0;
      bus1.c_raw      = 1'b0;

      test_reset();
      test_latency();
      test_glitch();
      test_simultaneous();
      test_saturate();
      test_reset_pending();
      test_db1();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 Parameter: DB_CYCLES, default 4, consecutive mismatch cycles required before an output flips; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: a_raw, b_raw, c_raw  input  1 each  asynchronous raw level inputs (buttons/strobes).
REQ-005 Port: glitch_clr  input  1  synchronous, clears glitch_cnt.
REQ-006 Port: a, b, c  output  1 each  registered, debounced levels feeding the downstream state machine.
REQ-007 Port: changed  output  1  registered one-cycle pulse, high in the cycle any of a/b/c shows a new value.
REQ-008 Port: glitch_cnt  output  8  registered saturating count of aborted transitions.

Function
REQ-009 Each channel SHALL pass its raw input through a two-flop synchronizer (s1, s2) before any other logic.
REQ-010 Each channel SHALL hold a debounce counter of width clog2(DB_CYCLES+1), forming two states: STABLE (cnt==0) and PENDING (cnt!=0).
REQ-011 At an edge where s2 != output: cnt==DB_CYCLES-1 -> output <= s2, cnt <= 0; otherwise cnt <= cnt+1.
REQ-012 At an edge where s2 == output: cnt <= 0; if cnt was nonzero, that channel aborted (glitch).
REQ-013 Latency: raw level first sampled at edge N and held stable SHALL appear on its output at edge N+DB_CYCLES+1; DB_CYCLES=1 gives N+2.
REQ-014 A raw pulse shorter than DB_CYCLES synchronized cycles SHALL never change the output.
REQ-015 changed SHALL be registered at the same edge as any output flip, high exactly one cycle per flipping edge, even if several channels flip together.
REQ-016 glitch_cnt SHALL increment by 1 at any edge where one or more channels abort, saturating at 255 (never wrapping).
REQ-017 glitch_clr SHALL set glitch_cnt to 0 at the next edge and wins over a simultaneous increment.
REQ-018 Channels SHALL operate independently; simultaneous transitions on multiple channels SHALL each follow REQ-011.

Reset
REQ-019 While reset is high at an edge: s1, s2, cnt, a, b, c, changed and glitch_cnt SHALL all be set to 0.
REQ-020 Reset during a PENDING transition SHALL discard it, with no flip, no changed pulse and no glitch count.
REQ-021 After reset deasserts, a raw input already high SHALL reach its output at edge R+DB_CYCLES+1, where R is the first non-reset edge.

Configuration
REQ-022 Macro INPUT_DEBOUNCE_EDGE_EN defined: adds outputs a_rise, b_rise, c_rise (1 bit each), each a registered one-cycle pulse at the edge its output flips 0->1; reset value 0.
REQ-023 Macro INPUT_DEBOUNCE_EDGE_EN undefined: rise ports and logic are absent; all other behaviour is identical.

Verification
REQ-024 DB_CYCLES=4, a_raw rises and holds from edge 10 -> a=1 and changed=1 at edge 15; changed=0 at edge 16.
REQ-025 DB_CYCLES=4, b_raw high for 2 cycles then low -> b stays 0, glitch_cnt becomes 1, changed never asserts.
REQ-026 a_raw and c_raw rise at the same edge -> a and c flip at the same edge with a single changed pulse; glitch_cnt is unchanged.
REQ-027 300 short glitches -> glitch_cnt saturates at 255; glitch_clr together with a glitch -> glitch_cnt=0 next cycle.
REQ-028 Reset asserted with cnt=2 pending on c -> c=0, cnt=0, changed=0 and glitch_cnt=0; the held raw level reappears per REQ-021.
REQ-029 EDGE_EN build: a 0->1 transition gives a_rise=1 for one cycle coincident with changed; a 1->0 transition gives a_rise=0.
